// File: rtl/brownout_dig.sv
// rtl/brownout_dig.sv - brown-out digital filter, trip decoders and sticky event flag; BROWNOUT_EVT_CNT_EN builds the event counter
module brownout_dig #(
  parameter int STARTUP_CYC = 16,
  parameter int DEB_CYC     = 8,
  parameter int HOLD_CYC    = 64,
  parameter int CNT_W       = 8
) (
  input  logic       osc_ck,
  input  logic       rstn,
  input  logic       ena,
  input  logic [2:0] otrip,
  input  logic [2:0] vtrip,
  input  logic       dcomp,
  input  logic       vunder,
  input  logic       evt_clr,
  output logic [7:0] otrip_decoded,
  output logic [7:0] vtrip_decoded,
  output logic       osc_ena,
  output logic       outb_unbuf,
  output logic       vunder_sync,
  output logic       brout_evt,
  output logic [7:0] evt_cnt
);

  typedef enum logic [1:0] {
    S_OFF,
    S_STARTUP,
    S_GOOD,
    S_BROWN
  } state_t;

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);

  logic             ena_m, ena_s;
  logic             dcomp_m, dcomp_s;
  logic             vunder_m, vunder_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             evt_set;

  // The oscillator enable must work while osc_ck is stopped, so it bypasses all flops.
  assign osc_ena     = ena;
  assign vunder_sync = vunder_s;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Two-flop synchronizers for the asynchronous enable and comparator inputs.
  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      ena_m    <= 1'b0;
      ena_s    <= 1'b0;
      dcomp_m  <= 1'b0;
      dcomp_s  <= 1'b0;
      vunder_m <= 1'b0;
      vunder_s <= 1'b0;
    end else begin
      ena_m    <= ena;
      ena_s    <= ena_m;
      dcomp_m  <= dcomp;
      dcomp_s  <= dcomp_m;
      vunder_m <= vunder;
      vunder_s <= vunder_m;
    end
  end

  // Registered one-hot trip decoders, refreshed every cycle.
  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      otrip_decoded <= 8'h01;
      vtrip_decoded <= 8'h01;
    end else begin
      otrip_decoded <= 8'h01 << otrip;
      vtrip_decoded <= 8'h01 << vtrip;
    end
  end

  // FSM state, shared settle/debounce/hold counter, and glitch-free output flop.
  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      outb_unbuf <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outb_unbuf <= (state_d == S_GOOD);
    end
  end

  // Next state: loss of enable overrides everything, otherwise settle then filter dcomp.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_set = 1'b0;
    if (!ena_s) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_STARTUP;
          cnt_d   = '0;
        end
        S_STARTUP: begin
          if (cnt_q == STARTUP_LAST) begin
            state_d = dcomp_s ? S_BROWN : S_GOOD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_GOOD: begin
          if (!dcomp_s) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = S_BROWN;
            cnt_d   = '0;
            evt_set = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_BROWN: begin
          if (dcomp_s) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = S_GOOD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Sticky GOOD->BROWN flag; a coincident new event beats the clear.
  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      brout_evt <= 1'b0;
    end else if (evt_set) begin
      brout_evt <= 1'b1;
    end else if (evt_clr) begin
      brout_evt <= 1'b0;
    end
  end

`ifdef BROWNOUT_EVT_CNT_EN
  logic [7:0] evt_cnt_q;

  // Saturating GOOD->BROWN event counter; a coincident new event beats the clear.
  always_ff @(posedge osc_ck or negedge rstn) begin
    if (!rstn) begin
      evt_cnt_q <= 8'h00;
    end else if (evt_set) begin
      if (evt_cnt_q != 8'hFF) begin
        evt_cnt_q <= evt_cnt_q + 8'd1;
      end
    end else if (evt_clr) begin
      evt_cnt_q <= 8'h00;
    end
  end

  assign evt_cnt = evt_cnt_q;
`else
  assign evt_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_brownout_dig.sv
// tb/tb_brownout_dig.sv - scoreboard bench for brownout_dig against a run-length reference model
module tb_brownout_dig;

  localparam int STARTUP_CYC = 16;
  localparam int DEB_CYC     = 8;
  localparam int HOLD_CYC    = 64;

  logic       osc_ck = 1'b0;
  logic       rstn, ena, dcomp, vunder, evt_clr;
  logic [2:0] otrip, vtrip;
  logic [7:0] otrip_decoded, vtrip_decoded, evt_cnt;
  logic       osc_ena, outb_unbuf, vunder_sync, brout_evt;

  always #5 osc_ck = ~osc_ck;

  brownout_dig dut (
    .osc_ck        (osc_ck),
    .rstn          (rstn),
    .ena           (ena),
    .otrip         (otrip),
    .vtrip         (vtrip),
    .dcomp         (dcomp),
    .vunder        (vunder),
    .evt_clr       (evt_clr),
    .otrip_decoded (otrip_decoded),
    .vtrip_decoded (vtrip_decoded),
    .osc_ena       (osc_ena),
    .outb_unbuf    (outb_unbuf),
    .vunder_sync   (vunder_sync),
    .brout_evt     (brout_evt),
    .evt_cnt       (evt_cnt)
  );

  typedef struct {
    logic       outb;
    logic       osc;
    logic       vs;
    logic       evt;
    logic [7:0] od;
    logic [7:0] vd;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: raw sample history plus run lengths of the synchronized comparator
  logic [2:0] raw_q[$];
  int         on_cnt, run1, run0, m_cnt;
  bit         m_good, m_evt, m_vs;
  logic [7:0] m_od, m_vd;

  task automatic model_edge(input bit r, input bit e, input bit d, input bit v,
                            input bit c, input logic [2:0] ot, input logic [2:0] vt);
    logic [2:0] old;
    bit         es, ds, evt_now;
    exp_t       x;
    evt_now = 1'b0;
    if (!r) begin
      raw_q.delete();
      raw_q.push_back(3'b000);
      raw_q.push_back(3'b000);
      on_cnt = 0; run1 = 0; run0 = 0; m_cnt = 0;
      m_good = 1'b0; m_evt = 1'b0; m_vs = 1'b0;
      m_od = 8'h01; m_vd = 8'h01;
    end else begin
      raw_q.push_back({v, d, e});
      old  = raw_q.pop_front();
      es   = old[0];
      ds   = old[1];
      old  = raw_q[0];
      m_vs = old[2];
      if (!es) begin
        on_cnt = 0; run1 = 0; run0 = 0; m_good = 1'b0;
      end else begin
        on_cnt++;
        if (ds) begin run1++; run0 = 0; end
        else    begin run0++; run1 = 0; end
        if (on_cnt == STARTUP_CYC + 1) begin
          m_good = !ds;
        end else if (on_cnt > STARTUP_CYC + 1) begin
          if (m_good && run1 == DEB_CYC) begin
            m_good  = 1'b0;
            evt_now = 1'b1;
          end else if (!m_good && run0 == HOLD_CYC) begin
            m_good = 1'b1;
          end
        end
      end
      if (evt_now) begin
        m_evt = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else if (c) begin
        m_evt = 1'b0;
        m_cnt = 0;
      end
      m_od = 8'h01 << ot;
      m_vd = 8'h01 << vt;
    end
    x.outb = m_good;
    x.osc  = e;
    x.vs   = m_vs;
    x.evt  = m_evt;
    x.od   = m_od;
    x.vd   = m_vd;
`ifdef BROWNOUT_EVT_CNT_EN
    x.cnt  = 8'(m_cnt);
`else
    x.cnt  = 8'h00;
`endif
    exp_q.push_back(x);
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit c,
                      input logic [2:0] ot, input logic [2:0] vt);
    bit v;
    @(negedge osc_ck);
    #1;
    v       = 1'($urandom_range(1, 0));
    rstn    = r;
    ena     = e;
    dcomp   = d;
    evt_clr = c;
    otrip   = ot;
    vtrip   = vt;
    vunder  = v;
    @(posedge osc_ck);
    model_edge(r, e, d, v, c, ot, vt);
  endtask

  task automatic st(input bit r, input bit e, input bit d, input bit c);
    step(r, e, d, c, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // monitor: compare the DUT against every queued expectation half a cycle after the edge
  initial begin
    exp_t x;
    forever begin
      @(negedge osc_ck);
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("outb_unbuf",    {7'b0, outb_unbuf},  {7'b0, x.outb});
        chk("osc_ena",       {7'b0, osc_ena},     {7'b0, x.osc});
        chk("vunder_sync",   {7'b0, vunder_sync}, {7'b0, x.vs});
        chk("brout_evt",     {7'b0, brout_evt},   {7'b0, x.evt});
        chk("otrip_decoded", otrip_decoded,       x.od);
        chk("vtrip_decoded", vtrip_decoded,       x.vd);
        chk("evt_cnt",       evt_cnt,             x.cnt);
      end
    end
  end

  initial begin
    rstn = 1'b0; ena = 1'b0; dcomp = 1'b0; vunder = 1'b0;
    evt_clr = 1'b0; otrip = 3'd0; vtrip = 3'd0;

    repeat (3) st(0, 0, 0, 0);
    // power-up with a quiet comparator
    repeat (30) st(1, 1, 0, 0);
    // short glitch train, then a real brown-out
    repeat (7) st(1, 1, 1, 0);
    repeat (5) st(1, 1, 0, 0);
    repeat (10) st(1, 1, 1, 0);
    // hysteresis: one pulse restarts the hold count
    repeat (63) st(1, 1, 0, 0);
    st(1, 1, 1, 0);
    repeat (70) st(1, 1, 0, 0);
    // disable in the middle of a brown-out hold count
    repeat (12) st(1, 1, 1, 0);
    repeat (20) st(1, 1, 0, 0);
    repeat (5) st(1, 0, 0, 0);
    repeat (25) st(1, 1, 0, 0);
    // clear held across the debounce so it coincides with the event edge
    for (int i = 0; i < 12; i++) st(1, 1, 1, (i <= 9));
    repeat (3) st(1, 1, 1, 0);
    repeat (70) st(1, 1, 0, 0);
    st(1, 1, 0, 1);
    repeat (3) st(1, 1, 0, 0);
    // decoder sweep
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 3'(i), 3'(7 - i));
    // randomized comparator runs, enable drops and one mid-operation reset
    for (int k = 0; k < 40; k++) begin
      int n1, n0;
      n1 = $urandom_range(12, 1);
      n0 = $urandom_range(90, 1);
      for (int j = 0; j < n1; j++) st(1, 1, 1, ($urandom_range(15, 0) == 0));
      for (int j = 0; j < n0; j++) st(1, 1, 0, ($urandom_range(15, 0) == 0));
      if ($urandom_range(7, 0) == 0) repeat (3) st(1, 0, 0, 0);
      if (k == 20) repeat (2) st(0, 1, 0, 0);
    end
`ifdef BROWNOUT_EVT_CNT_EN
    // saturate the event counter, then clear it
    repeat (3) st(1, 0, 0, 0);
    repeat (90) st(1, 1, 0, 0);
    for (int k = 0; k < 300; k++) begin
      repeat (10) st(1, 1, 1, 0);
      repeat (70) st(1, 1, 0, 0);
    end
    st(1, 1, 0, 1);
    repeat (3) st(1, 1, 0, 0);
`endif
    @(negedge osc_ck);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
